// File: rtl/ps2_key_ctrl_if.sv
// Key event port between the PS/2 front-end and the CPU keyboard register.
// The front-end is the master: it presents the FIFO head and the consumer answers with key_ready.
interface ps2_key_ctrl_if;
   logic [7:0] key_code;
   logic       key_ext;
   logic       key_brk;
   logic       key_valid;
   logic       key_ready;

   modport master (
      output key_code,
      output key_ext,
      output key_brk,
      output key_valid,
      input  key_ready
   );

   modport slave (
      input  key_code,
      input  key_ext,
      input  key_brk,
      input  key_valid,
      output key_ready
   );
endinterface

// File: rtl/ps2_key_ctrl.sv
// PS/2 keyboard front-end.
// The block oversamples the PS/2 lines and frames 11-bit packets. It checks parity and the stop bit.
// It folds E0/F0 prefixes into a single key event and buffers events in a small FWFT FIFO.
module ps2_key_ctrl #(
   parameter int TIMEOUT_CYC = 50000,
   parameter int FIFO_DEPTH  = 4,
   parameter int FIFO_AW     = 2
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               ps2_clk,
   input  logic               ps2_data,
   ps2_key_ctrl_if.master     kbd,
   output logic               frame_err,
   output logic               overflow
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SHIFT  = 2'd1,
      PARITY = 2'd2,
      STOP   = 2'd3
   } state_t;

   localparam int TW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
   localparam logic [TW-1:0]      TMO_LAST = TW'(TIMEOUT_CYC - 1);
   localparam logic [FIFO_AW:0]   FULL_CNT = (FIFO_AW+1)'(FIFO_DEPTH);

   // synchronisers and edge detection
   logic clk_s1, clk_s2, clk_prev;
   logic dat_s1, dat_s2;
   logic fall;

   // framing
   state_t         state, next_state;
   logic [2:0]     bit_cnt;
   logic [7:0]     shift_reg;
   logic           par_bit;
   logic [TW-1:0]  tmo_cnt;
   logic           timeout;
   logic           frame_ok;
   logic           frame_bad;

   // prefix folding
   logic           ext_flag, brk_flag;
   logic           is_e0, is_f0;
   logic           push;

   // event FIFO
   logic [9:0]       mem [FIFO_DEPTH];
   logic [FIFO_AW-1:0] wr_ptr, rd_ptr;
   logic [FIFO_AW:0] count;
   logic             fifo_valid;
   logic             full;
   logic             pop;
   logic             push_ok;
   logic             drop;

   // Two-flop synchronisers on both pad lines plus a history flop on the clock line; idle level is high
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         clk_s1   <= 1'b1;
         clk_s2   <= 1'b1;
         clk_prev <= 1'b1;
         dat_s1   <= 1'b1;
         dat_s2   <= 1'b1;
      end else begin
         clk_s1   <= ps2_clk;
         clk_s2   <= clk_s1;
         clk_prev <= clk_s2;
         dat_s1   <= ps2_data;
         dat_s2   <= dat_s1;
      end
   end

   assign fall = clk_prev & ~clk_s2;

   // Stall timer: counts idle cycles between PS/2 falling edges while a frame is open
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tmo_cnt <= '0;
      end else if ((state == IDLE) || fall) begin
         tmo_cnt <= '0;
      end else begin
         tmo_cnt <= tmo_cnt + TW'(1);
      end
   end

   assign timeout = (state != IDLE) && !fall && (tmo_cnt == TMO_LAST);

   // Frame state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Frame sequencing: advance only on PS/2 falling edges, judge the byte at the stop bit
   always_comb begin
      next_state = state;
      frame_ok   = 1'b0;
      frame_bad  = 1'b0;
      if (timeout) begin
         next_state = IDLE;
      end else if (fall) begin
         case (state)
            IDLE: begin
               if (!dat_s2) next_state = SHIFT;
            end
            SHIFT: begin
               if (bit_cnt == 3'd7) next_state = PARITY;
            end
            PARITY: begin
               next_state = STOP;
            end
            STOP: begin
               next_state = IDLE;
               if (dat_s2 && (^{shift_reg, par_bit})) frame_ok  = 1'b1;
               else                                   frame_bad = 1'b1;
            end
            default: next_state = IDLE;
         endcase
      end
   end

   // Data capture: LSB-first shift of the eight data bits, then the parity bit
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bit_cnt   <= 3'd0;
         shift_reg <= 8'd0;
         par_bit   <= 1'b0;
      end else if (fall && !timeout) begin
         case (state)
            IDLE: begin
               bit_cnt <= 3'd0;
            end
            SHIFT: begin
               shift_reg <= {dat_s2, shift_reg[7:1]};
               bit_cnt   <= bit_cnt + 3'd1;
            end
            PARITY: begin
               par_bit <= dat_s2;
            end
            default: begin
            end
         endcase
      end
   end

   assign is_e0 = frame_ok && (shift_reg == 8'hE0);
   assign is_f0 = frame_ok && (shift_reg == 8'hF0);
   assign push  = frame_ok && !is_e0 && !is_f0;

   // Prefix flags: remember E0/F0 until the real scancode arrives; any error or emitted event clears them
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ext_flag <= 1'b0;
         brk_flag <= 1'b0;
      end else if (timeout || frame_bad || push) begin
         ext_flag <= 1'b0;
         brk_flag <= 1'b0;
      end else if (is_e0) begin
         ext_flag <= 1'b1;
      end else if (is_f0) begin
         brk_flag <= 1'b1;
      end
   end

   assign fifo_valid = (count != '0);
   assign full       = (count == FULL_CNT);
   assign pop        = fifo_valid & kbd.key_ready;
   assign push_ok    = push & (~full | pop);
   assign drop       = push & full & ~pop;

   // FIFO storage; contents only matter while counted as valid, so no reset is needed
   always_ff @(posedge clk) begin
      if (push_ok) begin
         mem[wr_ptr] <= {ext_flag, brk_flag, shift_reg};
      end
   end

   // FIFO pointers and occupancy; a push into a full FIFO is allowed when the head leaves in the same cycle
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + FIFO_AW'(1);
         if (pop)     rd_ptr <= rd_ptr + FIFO_AW'(1);
         case ({push_ok, pop})
            2'b10:   count <= count + (FIFO_AW+1)'(1);
            2'b01:   count <= count - (FIFO_AW+1)'(1);
            default: count <= count;
         endcase
      end
   end

   // Status pulses registered so they are clean single-cycle strobes
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         frame_err <= 1'b0;
         overflow  <= 1'b0;
      end else begin
         frame_err <= timeout | frame_bad;
         overflow  <= drop;
      end
   end

   // Head presentation: show the oldest event while valid, otherwise drive zeros
   always_comb begin
      kbd.key_valid = fifo_valid;
      kbd.key_code  = 8'd0;
      kbd.key_ext   = 1'b0;
      kbd.key_brk   = 1'b0;
      if (fifo_valid) begin
         kbd.key_code = mem[rd_ptr][7:0];
         kbd.key_brk  = mem[rd_ptr][8];
         kbd.key_ext  = mem[rd_ptr][9];
      end
   end

endmodule

// File: tb/tb_ps2_key_ctrl.sv
// Self-checking bench for ps2_key_ctrl. The bench drives PS/2 frames bit by bit.
// Each task pushes the events it expects onto a queue, and a monitor collects the events the DUT hands over.
module tb_ps2_key_ctrl;

   localparam int HALF = 20;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic ps2_clk = 1'b1;
   logic ps2_data = 1'b1;
   logic frame_err;
   logic overflow;

   int errors = 0;
   int checks = 0;
   int ferr_cnt = 0;
   int ovf_cnt = 0;

   logic [9:0] exp_q[$];
   logic [9:0] obs_q[$];

   ps2_key_ctrl_if kif();

   ps2_key_ctrl #(
      .TIMEOUT_CYC(200),
      .FIFO_DEPTH (4),
      .FIFO_AW    (2)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .ps2_clk  (ps2_clk),
      .ps2_data (ps2_data),
      .kbd      (kif),
      .frame_err(frame_err),
      .overflow (overflow)
   );

   // System clock
   always #5 clk = ~clk;

   // Monitor: record every accepted event and count status pulses, sampled away from the active edge
   always @(negedge clk) begin
      if (rst_n) begin
         if (kif.key_valid && kif.key_ready)
            obs_q.push_back({kif.key_ext, kif.key_brk, kif.key_code});
         if (frame_err) ferr_cnt++;
         if (overflow)  ovf_cnt++;
      end
   end

   // Drive the first n bits of an 11-bit frame (bit 0 = start), data changes while the clock is high
   task automatic send_bits(input logic [10:0] f, input int n);
      for (int i = 0; i < n; i++) begin
         ps2_data = f[i];
         repeat (HALF) @(posedge clk);
         #1 ps2_clk = 1'b0;
         repeat (HALF) @(posedge clk);
         #1 ps2_clk = 1'b1;
      end
      ps2_data = 1'b1;
   endtask

   function automatic logic [10:0] make_frame(input logic [7:0] b, input logic bad_par);
      logic p;
      p = ~(^b) ^ bad_par;
      return {1'b1, p, b, 1'b0};
   endfunction

   task automatic send_byte(input logic [7:0] b, input logic bad_par);
      send_bits(make_frame(b, bad_par), 11);
      repeat (40) @(posedge clk);
   endtask

   task automatic test_reset();
      @(negedge clk);
      checks++; if (kif.key_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid: got %b expected 0", kif.key_valid); end
      checks++; if (kif.key_code !== 8'h00) begin errors++; $display("[TB] FAIL reset_code: got %h expected 00", kif.key_code); end
      checks++; if (kif.key_ext !== 1'b0) begin errors++; $display("[TB] FAIL reset_ext: got %b expected 0", kif.key_ext); end
      checks++; if (kif.key_brk !== 1'b0) begin errors++; $display("[TB] FAIL reset_brk: got %b expected 0", kif.key_brk); end
      checks++; if (frame_err !== 1'b0) begin errors++; $display("[TB] FAIL reset_ferr: got %b expected 0", frame_err); end
      checks++; if (overflow !== 1'b0) begin errors++; $display("[TB] FAIL reset_ovf: got %b expected 0", overflow); end
   endtask

   task automatic test_single();
      logic [9:0] e, o;
      int f0;
      f0 = ferr_cnt;
      kif.key_ready = 1'b1;
      exp_q.push_back({1'b0, 1'b0, 8'h1C});
      send_bits(make_frame(8'h1C, 1'b0), 10);
      ps2_data = 1'b1;
      repeat (HALF) @(posedge clk);
      #1 ps2_clk = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      checks++; if (kif.key_valid !== 1'b0) begin errors++; $display("[TB] FAIL single_early_valid: got %b expected 0", kif.key_valid); end
      @(posedge clk);
      @(negedge clk);
      checks++; if (kif.key_valid !== 1'b1) begin errors++; $display("[TB] FAIL single_latency_valid: got %b expected 1", kif.key_valid); end
      checks++; if (kif.key_code !== 8'h1C) begin errors++; $display("[TB] FAIL single_code: got %h expected 1c", kif.key_code); end
      @(posedge clk);
      @(negedge clk);
      checks++; if (kif.key_valid !== 1'b0) begin errors++; $display("[TB] FAIL single_one_cycle: got %b expected 0", kif.key_valid); end
      repeat (HALF) @(posedge clk);
      #1 ps2_clk = 1'b1;
      repeat (40) @(posedge clk);
      checks++; if (ferr_cnt !== f0) begin errors++; $display("[TB] FAIL single_ferr: got %0d expected %0d", ferr_cnt, f0); end
      checks++; if (obs_q.size() !== exp_q.size()) begin errors++; $display("[TB] FAIL single_count: got %0d expected %0d", obs_q.size(), exp_q.size()); end
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
         e = exp_q.pop_front(); o = obs_q.pop_front();
         checks++; if (o !== e) begin errors++; $display("[TB] FAIL single_event: got %h expected %h", o, e); end
      end
      exp_q.delete(); obs_q.delete();
   endtask

   task automatic test_prefix();
      logic [9:0] e, o;
      kif.key_ready = 1'b1;
      exp_q.push_back({1'b1, 1'b1, 8'h75});
      exp_q.push_back({1'b0, 1'b1, 8'h1C});
      send_byte(8'hE0, 1'b0);
      send_byte(8'hF0, 1'b0);
      send_byte(8'h75, 1'b0);
      send_byte(8'hF0, 1'b0);
      send_byte(8'h1C, 1'b0);
      checks++; if (obs_q.size() !== exp_q.size()) begin errors++; $display("[TB] FAIL prefix_count: got %0d expected %0d", obs_q.size(), exp_q.size()); end
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
         e = exp_q.pop_front(); o = obs_q.pop_front();
         checks++; if (o !== e) begin errors++; $display("[TB] FAIL prefix_event: got %h expected %h", o, e); end
      end
      exp_q.delete(); obs_q.delete();
   endtask

   task automatic test_parity();
      logic [9:0] e, o;
      int f0;
      f0 = ferr_cnt;
      kif.key_ready = 1'b1;
      send_byte(8'h1C, 1'b1);
      checks++; if (ferr_cnt !== f0 + 1) begin errors++; $display("[TB] FAIL parity_ferr: got %0d expected %0d", ferr_cnt, f0 + 1); end
      checks++; if (obs_q.size() !== 0) begin errors++; $display("[TB] FAIL parity_no_event: got %0d expected 0", obs_q.size()); end
      exp_q.push_back({1'b0, 1'b0, 8'h32});
      send_byte(8'h32, 1'b0);
      checks++; if (ferr_cnt !== f0 + 1) begin errors++; $display("[TB] FAIL parity_ferr_after: got %0d expected %0d", ferr_cnt, f0 + 1); end
      checks++; if (obs_q.size() !== exp_q.size()) begin errors++; $display("[TB] FAIL parity_count: got %0d expected %0d", obs_q.size(), exp_q.size()); end
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
         e = exp_q.pop_front(); o = obs_q.pop_front();
         checks++; if (o !== e) begin errors++; $display("[TB] FAIL parity_event: got %h expected %h", o, e); end
      end
      exp_q.delete(); obs_q.delete();
   endtask

   task automatic test_timeout();
      logic [9:0] e, o;
      int f0;
      f0 = ferr_cnt;
      kif.key_ready = 1'b1;
      send_bits(make_frame(8'h1C, 1'b0), 5);
      repeat (150) @(posedge clk);
      checks++; if (ferr_cnt !== f0) begin errors++; $display("[TB] FAIL timeout_early: got %0d expected %0d", ferr_cnt, f0); end
      repeat (150) @(posedge clk);
      checks++; if (ferr_cnt !== f0 + 1) begin errors++; $display("[TB] FAIL timeout_ferr: got %0d expected %0d", ferr_cnt, f0 + 1); end
      exp_q.push_back({1'b0, 1'b0, 8'h1C});
      send_byte(8'h1C, 1'b0);
      checks++; if (obs_q.size() !== exp_q.size()) begin errors++; $display("[TB] FAIL timeout_count: got %0d expected %0d", obs_q.size(), exp_q.size()); end
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
         e = exp_q.pop_front(); o = obs_q.pop_front();
         checks++; if (o !== e) begin errors++; $display("[TB] FAIL timeout_event: got %h expected %h", o, e); end
      end
      exp_q.delete(); obs_q.delete();
   endtask

   task automatic test_overflow();
      logic [9:0] e, o;
      logic [7:0] codes [5];
      int v0;
      codes[0] = 8'h1C; codes[1] = 8'h32; codes[2] = 8'h21; codes[3] = 8'h23; codes[4] = 8'h24;
      v0 = ovf_cnt;
      kif.key_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         exp_q.push_back({2'b00, codes[i]});
         send_byte(codes[i], 1'b0);
      end
      checks++; if (ovf_cnt !== v0) begin errors++; $display("[TB] FAIL ovf_early: got %0d expected %0d", ovf_cnt, v0); end
      send_byte(codes[4], 1'b0);
      checks++; if (ovf_cnt !== v0 + 1) begin errors++; $display("[TB] FAIL ovf_pulse: got %0d expected %0d", ovf_cnt, v0 + 1); end
      checks++; if (kif.key_valid !== 1'b1) begin errors++; $display("[TB] FAIL ovf_valid_held: got %b expected 1", kif.key_valid); end
      checks++; if (obs_q.size() !== 0) begin errors++; $display("[TB] FAIL ovf_no_pop: got %0d expected 0", obs_q.size()); end
      @(posedge clk);
      #1 kif.key_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         checks++; if (kif.key_valid !== 1'b1 || kif.key_code !== codes[i]) begin
            errors++; $display("[TB] FAIL ovf_drain_%0d: got valid=%b code=%h expected valid=1 code=%h", i, kif.key_valid, kif.key_code, codes[i]);
         end
      end
      @(negedge clk);
      checks++; if (kif.key_valid !== 1'b0) begin errors++; $display("[TB] FAIL ovf_empty: got %b expected 0", kif.key_valid); end
      checks++; if (obs_q.size() !== exp_q.size()) begin errors++; $display("[TB] FAIL ovf_count: got %0d expected %0d", obs_q.size(), exp_q.size()); end
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
         e = exp_q.pop_front(); o = obs_q.pop_front();
         checks++; if (o !== e) begin errors++; $display("[TB] FAIL ovf_event: got %h expected %h", o, e); end
      end
      exp_q.delete(); obs_q.delete();
   endtask

   task automatic test_reset_mid();
      logic [9:0] e, o;
      int f0;
      kif.key_ready = 1'b0;
      send_byte(8'h32, 1'b0);
      checks++; if (kif.key_valid !== 1'b1) begin errors++; $display("[TB] FAIL rstmid_pre_valid: got %b expected 1", kif.key_valid); end
      send_bits(make_frame(8'h1C, 1'b0), 6);
      f0 = ferr_cnt;
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      checks++; if (kif.key_valid !== 1'b0) begin errors++; $display("[TB] FAIL rstmid_valid: got %b expected 0", kif.key_valid); end
      checks++; if (kif.key_code !== 8'h00) begin errors++; $display("[TB] FAIL rstmid_code: got %h expected 00", kif.key_code); end
      checks++; if (frame_err !== 1'b0 || overflow !== 1'b0) begin errors++; $display("[TB] FAIL rstmid_pulses: got ferr=%b ovf=%b expected 0 0", frame_err, overflow); end
      repeat (5) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (300) @(posedge clk);
      checks++; if (ferr_cnt !== f0) begin errors++; $display("[TB] FAIL rstmid_ferr: got %0d expected %0d", ferr_cnt, f0); end
      kif.key_ready = 1'b1;
      exp_q.push_back({1'b0, 1'b0, 8'h1C});
      send_byte(8'h1C, 1'b0);
      checks++; if (obs_q.size() !== exp_q.size()) begin errors++; $display("[TB] FAIL rstmid_count: got %0d expected %0d", obs_q.size(), exp_q.size()); end
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
         e = exp_q.pop_front(); o = obs_q.pop_front();
         checks++; if (o !== e) begin errors++; $display("[TB] FAIL rstmid_event: got %h expected %h", o, e); end
      end
      exp_q.delete(); obs_q.delete();
   endtask

   // Test sequence
   initial begin
      kif.key_ready = 1'b0;
      rst_n = 1'b0;
      repeat (4) @(posedge clk);
      test_reset();
      @(negedge clk);
      rst_n = 1'b1;
      repeat (4) @(posedge clk);
      test_single();
      test_prefix();
      test_parity();
      test_timeout();
      test_overflow();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
